// File: rtl/nios_core_nios2_cpu_debug_scan_master_if.sv
// rtl/nios_core_nios2_cpu_debug_scan_master_if.sv - command/response bundle for the debug scan master
interface nios_core_nios2_cpu_debug_scan_master_if #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [IR_WIDTH-1:0] cmd_ir;
    logic [DR_WIDTH-1:0] cmd_data;
    logic                rsp_valid;
    logic [DR_WIDTH-1:0] rsp_data;

    modport master (
        output cmd_valid, cmd_ir, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/nios_core_nios2_cpu_debug_scan_master.sv
// rtl/nios_core_nios2_cpu_debug_scan_master.sv - drives the Nios II debug slave vji_* pins from parallel scan commands
module nios_core_nios2_cpu_debug_scan_master #(
    parameter int DR_WIDTH = 38,
    parameter int IR_WIDTH = 2,
    parameter int TCK_DIV  = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    nios_core_nios2_cpu_debug_scan_master_if.slave cmd,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [IR_WIDTH-1:0] vji_ir_in,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam int PER_W = $clog2(DR_WIDTH + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [PER_W-1:0] SDR_LAST = PER_W'(DR_WIDTH - 1);

    typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI} state_t;

    state_t              state, state_nx;
    logic [DIV_W-1:0]    div_cnt, div_nx;
    logic                tck_nx;
    logic [PER_W-1:0]    per, per_nx;
    logic [DR_WIDTH-1:0] shift, shift_nx;
    logic [IR_WIDTH-1:0] ir_nx;
    logic                tdi_nx;
    logic                done;

    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        tck_nx   = vji_tck;
        per_nx   = per;
        shift_nx = shift;
        ir_nx    = vji_ir_in;
        tdi_nx   = 1'b0;
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd.cmd_valid && cmd.cmd_ready) begin
                    state_nx = S_UIR;
                    shift_nx = cmd.cmd_data;
                    ir_nx    = cmd.cmd_ir;
                    div_nx   = '0;
                    tck_nx   = 1'b0;
                    per_nx   = '0;
                end
            end
            default: begin
                if (div_cnt == DIV_LAST) begin
                    div_nx = '0;
                    tck_nx = ~vji_tck;
                    if (!vji_tck) begin
                        // TDO is captured on the edge that raises TCK
                        if (state == S_SDR) shift_nx = {vji_tdo, shift[DR_WIDTH-1:1]};
                    end else if (per == ((state == S_SDR) ? SDR_LAST : PER_W'(0))) begin
                        per_nx = '0;
                        case (state)
                            S_UIR:   state_nx = S_CDR;
                            S_CDR:   state_nx = S_SDR;
                            S_SDR:   state_nx = S_UDR;
                            S_UDR:   state_nx = S_RTI;
                            default: begin
                                state_nx = S_IDLE;
                                done     = 1'b1;
                            end
                        endcase
                    end else begin
                        per_nx = per + 1'b1;
                    end
                end else begin
                    div_nx = div_cnt + 1'b1;
                end
            end
        endcase
        // TDI only moves at the start of a TCK period so it straddles the rising edge
        if (state_nx == S_SDR) begin
            tdi_nx = (!tck_nx && div_nx == '0) ? shift_nx[0] : vji_tdi;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            div_cnt       <= '0;
            per           <= '0;
            shift         <= '0;
            vji_tck       <= 1'b0;
            vji_tdi       <= 1'b0;
            vji_ir_in     <= '0;
            vji_uir       <= 1'b0;
            vji_cdr       <= 1'b0;
            vji_sdr       <= 1'b0;
            vji_udr       <= 1'b0;
            vji_rti       <= 1'b0;
            cmd.cmd_ready <= 1'b0;
            cmd.rsp_valid <= 1'b0;
            cmd.rsp_data  <= '0;
        end else begin
            state         <= state_nx;
            div_cnt       <= div_nx;
            per           <= per_nx;
            shift         <= shift_nx;
            vji_tck       <= tck_nx;
            vji_tdi       <= tdi_nx;
            vji_ir_in     <= ir_nx;
            vji_uir       <= (state_nx == S_UIR);
            vji_cdr       <= (state_nx == S_CDR);
            vji_sdr       <= (state_nx == S_SDR);
            vji_udr       <= (state_nx == S_UDR);
            vji_rti       <= (state_nx == S_RTI);
            cmd.cmd_ready <= (state_nx == S_IDLE);
            cmd.rsp_valid <= done;
            if (done) cmd.rsp_data <= shift_nx;
        end
    end
endmodule

// File: tb/tb_nios_core_nios2_cpu_debug_scan_master.sv
// tb/tb_nios_core_nios2_cpu_debug_scan_master.sv - randomized bench with per-cycle reference model, TCK_DIV 2 and 1
module tb_nios_core_nios2_cpu_debug_scan_master;
    localparam int DRW = 38;
    localparam int IRW = 2;
    localparam int VW  = 1 + 1 + DRW + 1 + 1 + IRW + 5;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    nios_core_nios2_cpu_debug_scan_master_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) bus0 ();
    nios_core_nios2_cpu_debug_scan_master_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) bus1 ();

    logic           cmd_valid [2];
    logic [IRW-1:0] cmd_ir    [2];
    logic [DRW-1:0] cmd_data  [2];
    logic [1:0]     rdy, rv, tck, tdi, tdo, uir, cdr, sdr, udr, rti;
    logic [DRW-1:0] rd        [2];
    logic [IRW-1:0] ir_in     [2];

    assign bus0.cmd_valid = cmd_valid[0];
    assign bus0.cmd_ir    = cmd_ir[0];
    assign bus0.cmd_data  = cmd_data[0];
    assign bus1.cmd_valid = cmd_valid[1];
    assign bus1.cmd_ir    = cmd_ir[1];
    assign bus1.cmd_data  = cmd_data[1];
    assign rdy = {bus1.cmd_ready, bus0.cmd_ready};
    assign rv  = {bus1.rsp_valid, bus0.rsp_valid};
    assign rd[0] = bus0.rsp_data;
    assign rd[1] = bus1.rsp_data;

    nios_core_nios2_cpu_debug_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .cmd(bus0),
        .vji_tck(tck[0]), .vji_tdi(tdi[0]), .vji_tdo(tdo[0]), .vji_ir_in(ir_in[0]),
        .vji_uir(uir[0]), .vji_cdr(cdr[0]), .vji_sdr(sdr[0]), .vji_udr(udr[0]), .vji_rti(rti[0])
    );
    nios_core_nios2_cpu_debug_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .cmd(bus1),
        .vji_tck(tck[1]), .vji_tdi(tdi[1]), .vji_tdo(tdo[1]), .vji_ir_in(ir_in[1]),
        .vji_uir(uir[1]), .vji_cdr(cdr[1]), .vji_sdr(sdr[1]), .vji_udr(udr[1]), .vji_rti(rti[1])
    );

    // Debug-slave DR: shifts TDI in on each TCK rise during SDR, presents bit 0 on TDO
    logic [DRW-1:0] sreg [2];
    logic           tie1 [2];
    for (genvar g = 0; g < 2; g++) begin : g_slave
        assign tdo[g] = tie1[g] ? 1'b1 : sreg[g][0];
        always @(posedge tck[g]) if (sdr[g]) sreg[g] = {tdi[g], sreg[g][DRW-1:1]};
    end

    int n_checks = 0;
    int n_fail   = 0;
    int n_printed = 0;

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int scan_len(input int i);
        return 2 * div_of(i) * (DRW + 4);
    endfunction

    // Model: 0 = held/just released, 1 = idle, 2 = scanning (k = cycle within scan), 3 = response cycle
    int             mode [2];
    int             k    [2];
    logic [IRW-1:0] m_ir   [2];
    logic [DRW-1:0] m_data [2];
    logic [DRW-1:0] m_cap  [2];
    logic [DRW-1:0] m_rsp  [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                mode[i]  = 0;
                m_ir[i]  = '0;
                m_rsp[i] = '0;
            end else begin
                case (mode[i])
                    0: mode[i] = 1;
                    2: begin
                        if (k[i] == scan_len(i)) begin
                            mode[i]  = 3;
                            m_rsp[i] = m_cap[i];
                        end else begin
                            k[i] = k[i] + 1;
                        end
                    end
                    default: begin
                        if (cmd_valid[i]) begin
                            mode[i]   = 2;
                            k[i]      = 1;
                            m_ir[i]   = cmd_ir[i];
                            m_data[i] = cmd_data[i];
                            m_cap[i]  = tie1[i] ? {DRW{1'b1}} : sreg[i];
                        end else begin
                            mode[i] = 1;
                        end
                    end
                endcase
            end
        end
    end

    function automatic logic [VW-1:0] expect_out(input int i);
        logic       cr, v, tk, td;
        logic [4:0] st;
        int         p, d;
        cr = 1'b0; v = 1'b0; tk = 1'b0; td = 1'b0; st = 5'b0;
        if (!reset_n) return '0;
        d = div_of(i);
        case (mode[i])
            1: cr = 1'b1;
            3: begin cr = 1'b1; v = 1'b1; end
            2: begin
                p  = (k[i] - 1) / (2 * d);
                tk = (((k[i] - 1) % (2 * d)) >= d);
                if (p == 0)            st = 5'b10000;
                else if (p == 1)       st = 5'b01000;
                else if (p < DRW + 2) begin
                    st = 5'b00100;
                    td = m_data[i][p-2];
                end
                else if (p == DRW + 2) st = 5'b00010;
                else                   st = 5'b00001;
            end
            default: ;
        endcase
        return {cr, v, m_rsp[i], tk, td, m_ir[i], st};
    endfunction

    function automatic logic [VW-1:0] actual_out(input int i);
        return {rdy[i], rv[i], rd[i], tck[i], tdi[i], ir_in[i], uir[i], cdr[i], sdr[i], udr[i], rti[i]};
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [VW-1:0] e, a;
            e = expect_out(i);
            a = actual_out(i);
            n_checks++;
            if (a !== e) begin
                n_fail++;
                if (n_printed < 30) begin
                    n_printed++;
                    $display("FAIL cycle_model dut%0d t=%0t actual=%h required=%h", i, $time, a, e);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int i);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy[i] && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_cmd(input int i, input logic [IRW-1:0] ir, input logic [DRW-1:0] data,
                          output int lat, output logic [DRW-1:0] rdata, output logic [IRW-1:0] ir1);
        wait_ready(i);
        cmd_ir[i]    = ir;
        cmd_data[i]  = data;
        cmd_valid[i] = 1'b1;
        @(posedge clk);
        #1 cmd_valid[i] = 1'b0;
        lat   = -1;
        rdata = '0;
        @(negedge clk);
        ir1 = ir_in[i];
        for (int c = 1; c <= 400; c++) begin
            if (rv[i]) begin
                lat   = c;
                rdata = rd[i];
                break;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [DRW-1:0] rand_dr();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DRW-1:0];
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int             lat, lat1, pulses;
        logic [DRW-1:0] r, r1, pre0, pre1, d0, d1;
        logic [IRW-1:0] i0, i1, irs [3];
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i] = 1'b0;
            cmd_ir[i]    = '0;
            cmd_data[i]  = '0;
            tie1[i]      = 1'b0;
            sreg[i]      = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_dut0", actual_out(0), '0);
        check("reset_outputs_dut1", actual_out(1), '0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_before_first_edge", rdy[0], 1'b0);
        @(negedge clk);
        check("ready_after_release", rdy[0], 1'b1);

        tie1[0] = 1'b1;
        do_cmd(0, 2'b01, 38'h2A_AAAA_AAAA, lat, r, i0);
        check("tie1_ir_t0p1", i0, 2'b01);
        check("tie1_latency", lat, 169);
        check("tie1_rsp", r, 38'h3F_FFFF_FFFF);
        tie1[0] = 1'b0;

        sreg[0] = 38'h12_3456_789A;
        do_cmd(0, 2'b10, 38'h0, lat, r, i0);
        check("slave_rsp", r, 38'h12_3456_789A);
        check("slave_shifted_in", sreg[0], 38'h0);
        do_cmd(0, 2'b11, 38'h15_0F0F_00FF, lat, r, i0);
        check("slave_second_rsp", r, 38'h0);
        check("slave_second_shifted_in", sreg[0], 38'h15_0F0F_00FF);

        irs[0] = 2'b00; irs[1] = 2'b10; irs[2] = 2'b11;
        wait_ready(0);
        cmd_ir[0]    = irs[0];
        cmd_data[0]  = rand_dr();
        cmd_valid[0] = 1'b1;
        pulses = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            if (c < 2) begin
                cmd_ir[0]   = irs[c+1];
                cmd_data[0] = rand_dr();
            end else begin
                cmd_valid[0] = 1'b0;
            end
            lat = -1;
            for (int n = 1; n <= 400; n++) begin
                @(negedge clk);
                if (n == 1) check("burst_ir", ir_in[0], irs[c]);
                if (rv[0]) begin
                    lat = n;
                    break;
                end
            end
            check("burst_gap", lat, 169);
            if (lat > 0) pulses++;
        end
        check("burst_pulses", pulses, 3);

        wait_ready(0);
        cmd_ir[0]    = 2'b01;
        cmd_data[0]  = rand_dr();
        cmd_valid[0] = 1'b1;
        @(posedge clk);
        #1 cmd_valid[0] = 1'b0;
        repeat (60) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_dut0", actual_out(0), '0);
        check("async_reset_dut1", actual_out(1), '0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        sreg[0] = 38'h0A_5A5A_C3C3;
        do_cmd(0, 2'b10, rand_dr(), lat, r, i0);
        check("post_reset_latency", lat, 169);
        check("post_reset_rsp", r, 38'h0A_5A5A_C3C3);

        sreg[1] = 38'h12_3456_789A;
        do_cmd(1, 2'b01, 38'h0, lat, r, i0);
        check("div1_latency", lat, 85);
        check("div1_rsp", r, 38'h12_3456_789A);

        for (int it = 0; it < 24; it++) begin
            tie1[0] = ($urandom_range(0, 3) == 0);
            tie1[1] = ($urandom_range(0, 3) == 0);
            pre0 = rand_dr();
            pre1 = rand_dr();
            sreg[0] = pre0;
            sreg[1] = pre1;
            d0 = rand_dr();
            d1 = rand_dr();
            i0 = IRW'($urandom_range(0, 3));
            i1 = IRW'($urandom_range(0, 3));
            repeat ($urandom_range(0, 5)) @(posedge clk);
            fork
                begin
                    logic [IRW-1:0] seen0;
                    do_cmd(0, i0, d0, lat, r, seen0);
                    check("rand_ir_dut0", seen0, i0);
                end
                begin
                    logic [IRW-1:0] seen1;
                    repeat ($urandom_range(0, 40)) @(posedge clk);
                    do_cmd(1, i1, d1, lat1, r1, seen1);
                    check("rand_ir_dut1", seen1, i1);
                end
            join
            check("rand_latency_dut0", lat, scan_len(0) + 1);
            check("rand_latency_dut1", lat1, scan_len(1) + 1);
            check("rand_rsp_dut0", r, tie1[0] ? {DRW{1'b1}} : pre0);
            check("rand_rsp_dut1", r1, tie1[1] ? {DRW{1'b1}} : pre1);
            check("rand_shift_in_dut0", sreg[0], d0);
            check("rand_shift_in_dut1", sreg[1], d1);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nios_core_nios2_cpu_debug_scan_master.md
# nios_core_nios2_cpu_debug_scan_master

On-chip initiator for the Nios II debug slave's virtual-JTAG interface. It accepts parallel scan commands (a 2-bit IR value plus a 38-bit DR word) in the `clk` domain. For each command it generates the virtual-JTAG strobe sequence (UIR, CDR, SDR, UDR, RTI), shifts the DR word out on `vji_tdi`, and returns the 38 bits captured from `vji_tdo`. It drives the debug slave's `vji_*` pins directly, in place of the hard JTAG hub, for self-test and embedded-host debug access.

## Interface
- `DR_WIDTH`, default 38: data-register scan length in bits.
- `IR_WIDTH`, default 2: instruction-register width.
- `TCK_DIV`, default 2: `clk` cycles per TCK half-period; legal range ≥1.

Ports:
- `clk` in 1: single system clock; all logic is rising-edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: block is idle and can accept a command.
- `cmd_ir` in IR_WIDTH: IR value for the scan.
- `cmd_data` in DR_WIDTH: DR word to shift out, LSB first.
- `rsp_valid` out 1: one-cycle pulse; `rsp_data` is valid in that cycle.
- `rsp_data` out DR_WIDTH: captured TDO bits; bit 0 is the first captured bit.
- `vji_tck` out 1: generated TCK.
- `vji_tdi` out 1: serial data to the slave.
- `vji_tdo` in 1: serial data from the slave.
- `vji_ir_in` out IR_WIDTH: current IR value.
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `vji_rti` out 1 each: virtual-state strobes.

## Operation
- FSM states: IDLE, UIR, CDR, SDR, UDR, RTI.
- Each non-IDLE state lasts a whole number of TCK periods. One TCK period is 2·TCK_DIV `clk` cycles: the low half-period comes first, then the high half-period.
- IDLE:
  - `cmd_ready` is 1 and `vji_tck` is 0.
  - On `cmd_valid && cmd_ready`, latch `cmd_ir` and `cmd_data` into the shift register and go to UIR.
- UIR (1 TCK period):
  - `vji_ir_in` loads the latched IR on entry.
  - `vji_uir` is 1.
- CDR (1 TCK period): `vji_cdr` is 1.
- SDR (DR_WIDTH TCK periods): `vji_sdr` is 1.
  - `vji_tdi` is `shift[0]` for the whole period.
  - On the `clk` edge that raises `vji_tck`: `shift <= {vji_tdo, shift[DR_WIDTH-1:1]}`.
  - After DR_WIDTH periods, `shift` holds the captured TDO bits, first bit in bit 0.
- UDR (1 TCK period): `vji_udr` is 1.
- RTI (1 TCK period): `vji_rti` is 1.
- Leaving RTI:
  - Go to IDLE.
  - `rsp_valid` is 1 for exactly one cycle, with `rsp_data` = `shift`.
  - `cmd_ready` is 1 in that same cycle.
- `vji_ir_in` holds its last value between commands; it changes only on UIR entry or reset.
- `rsp_data` holds its value until the next response.
- Strobes are mutually exclusive. `vji_tdi` is 0 outside SDR.
- `cmd_valid` is ignored while `cmd_ready` is 0. No command is queued.
- There is no response backpressure: `rsp_valid` is a pulse only.
- All outputs are registered.

## Timing
- Reset values while `reset_n` is 0: every output is 0, including `cmd_ready`, `rsp_valid`, `rsp_data`, `vji_ir_in`, `vji_tck` and all strobes. The FSM is in IDLE and the TCK divider counter is 0.
- `cmd_ready` rises in the first `clk` cycle after reset release.
- Reset asserted mid-scan: abort immediately. No `rsp_valid` is produced. The next command after release runs a full sequence from UIR.
- Handshake at cycle t0: UIR strobe and `vji_ir_in` update are visible at t0+1.
- Total scan length:
  - (DR_WIDTH+4) TCK periods = 2·TCK_DIV·(DR_WIDTH+4) cycles.
  - With defaults this is 168 cycles, so `rsp_valid` is at t0+169.
- Back-to-back: if `cmd_valid` is 1 during the `rsp_valid` cycle, it is accepted there (t1 = t0+169). The next UIR starts at t1+1.
- TCK_DIV=1: `vji_tck` toggles every `clk` cycle, giving a 50% duty cycle. Edge and strobe alignment rules are unchanged.
- `vji_tdo` is sampled only on `vji_tck` rising edges during SDR. At those edges `vji_tdi` is stable for at least TCK_DIV cycles before and after.

## Test plan
- Reset, then `cmd_ir`=2'b01, `cmd_data`=38'h2A_AAAA_AAAA, `vji_tdo` tied 1:
  - `vji_ir_in`=2'b01 at t0+1.
  - `vji_tdi` sampled at the 38 TCK rises reads 0,1,0,1,… (LSB first).
  - `rsp_valid` at t0+169 with `rsp_data`=38'h3F_FFFF_FFFF.
- Slave model (38-bit shift register preloaded with 38'h12_3456_789A), `cmd_data`=38'h0:
  - `rsp_data`=38'h12_3456_789A.
  - A second scan returns 38'h0.
- Strobe-order check with a monitor:
  - Exactly one TCK period each of UIR, then CDR.
  - 38 periods of SDR.
  - One period each of UDR, then RTI.
  - No overlap between strobes; `cmd_ready`=0 throughout.
- `cmd_valid` held high for 3 commands with IRs 2'b00, 2'b10, 2'b11:
  - Acceptances at t0, t0+169, t0+338.
  - `vji_ir_in` follows the IR sequence.
  - 3 `rsp_valid` pulses.
- Assert `reset_n`=0 at t0+60 (mid-SDR):
  - All outputs go to 0 asynchronously.
  - No `rsp_valid`.
  - After release, a new command completes normally in 169 cycles.
- TCK_DIV=1, defaults otherwise:
  - `vji_tck` period is 2 cycles.
  - `rsp_valid` at t0+85.
  - Slave-model data returned intact.
